// File: rtl/riscv_lsu_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
// Single outstanding request: req/gnt handshake followed by an rvalid response.
interface riscv_lsu_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  o_mem_req;
  logic                  o_mem_wr_en;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [3:0]            o_mem_byte_en;
  logic [31:0]           o_mem_wdata;
  logic                  i_mem_gnt;
  logic                  i_mem_rvalid;
  logic [31:0]           i_mem_rdata;

  modport master (
    output o_mem_req, o_mem_wr_en, o_mem_addr, o_mem_byte_en, o_mem_wdata,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata
  );

  modport slave (
    input  o_mem_req, o_mem_wr_en, o_mem_addr, o_mem_byte_en, o_mem_wdata,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata
  );
endinterface

// File: rtl/riscv_lsu.sv
// Load/store unit: one word-aligned bus access per core request, with lane alignment and load extension.
// Optional bus timeout abort is enabled by defining RISCV_LSU_TIMEOUT_EN.
module riscv_lsu #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_lsu_req,
  input  logic                  i_lsu_wr_en,
  input  logic [2:0]            i_lsu_funct3,
  input  logic [ADDR_WIDTH-1:0] i_lsu_addr,
  input  logic [31:0]           i_lsu_wdata,
  output logic [31:0]           o_lsu_rdata,
  output logic                  o_lsu_done,
  output logic                  o_lsu_stall,
  output logic                  o_lsu_misalign,
  output logic                  o_lsu_fault,
  riscv_lsu_if.master           mem_bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Reserved funct3 codes fall through to word behaviour in every helper.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000, 3'b100: is_misaligned = 1'b0;
      3'b001, 3'b101: is_misaligned = off[0];
      default:        is_misaligned = (off != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000, 3'b100: store_be = 4'b0001 << off;
      3'b001, 3'b101: store_be = 4'b0011 << off;
      default:        store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000, 3'b100: store_data = {4{d[7:0]}};
      3'b001, 3'b101: store_data = {2{d[15:0]}};
      default:        store_data = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  load_extract = {{24{sh[7]}}, sh[7:0]};
      3'b100:  load_extract = {24'h0, sh[7:0]};
      3'b001:  load_extract = {{16{sh[15]}}, sh[15:0]};
      3'b101:  load_extract = {16'h0, sh[15:0]};
      default: load_extract = word;
    endcase
  endfunction

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_en_q, wr_en_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [1:0]            off_q, off_d;
  logic [2:0]            f3_q, f3_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  misalign_q, misalign_d;

`ifdef RISCV_LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_en_d    = wr_en_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    off_d      = off_q;
    f3_d       = f3_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
`ifdef RISCV_LSU_TIMEOUT_EN
    cnt_d      = cnt_q;
    fault_d    = fault_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_lsu_req) begin
          if (is_misaligned(i_lsu_funct3, i_lsu_addr[1:0])) begin
            misalign_d = 1'b1;
            rdata_d    = 32'h0;
            state_d    = S_DONE;
          end else begin
            addr_d  = {i_lsu_addr[ADDR_WIDTH-1:2], 2'b00};
            wr_en_d = i_lsu_wr_en;
            be_d    = i_lsu_wr_en ? store_be(i_lsu_funct3, i_lsu_addr[1:0]) : 4'b1111;
            wdata_d = store_data(i_lsu_funct3, i_lsu_wdata);
            off_d   = i_lsu_addr[1:0];
            f3_d    = i_lsu_funct3;
            state_d = S_REQ;
`ifdef RISCV_LSU_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      S_REQ: begin
        if (mem_bus.i_mem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_bus.i_mem_rvalid) begin
          if (!wr_en_q) rdata_d = load_extract(f3_q, off_q, mem_bus.i_mem_rdata);
          state_d = S_DONE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        misalign_d = 1'b0;
`ifdef RISCV_LSU_TIMEOUT_EN
        fault_d    = 1'b0;
`endif
      end
    endcase
`ifdef RISCV_LSU_TIMEOUT_EN
    // A response arriving on the limit cycle still completes the access normally.
    if (state_q == S_REQ || state_q == S_WAIT) begin
      cnt_d = cnt_q + 1'b1;
      if (state_d != S_DONE && cnt_d >= CNT_LIMIT) begin
        state_d = S_DONE;
        fault_d = 1'b1;
        rdata_d = 32'h0;
      end
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wr_en_q    <= 1'b0;
      be_q       <= 4'h0;
      wdata_q    <= 32'h0;
      off_q      <= 2'b00;
      f3_q       <= 3'b000;
      rdata_q    <= 32'h0;
      misalign_q <= 1'b0;
`ifdef RISCV_LSU_TIMEOUT_EN
      cnt_q      <= '0;
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_en_q    <= wr_en_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      off_q      <= off_d;
      f3_q       <= f3_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
`ifdef RISCV_LSU_TIMEOUT_EN
      cnt_q      <= cnt_d;
      fault_q    <= fault_d;
`endif
    end
  end

  assign mem_bus.o_mem_req     = (state_q == S_REQ);
  assign mem_bus.o_mem_wr_en   = wr_en_q;
  assign mem_bus.o_mem_addr    = addr_q;
  assign mem_bus.o_mem_byte_en = be_q;
  assign mem_bus.o_mem_wdata   = wdata_q;

  assign o_lsu_rdata    = rdata_q;
  assign o_lsu_done     = (state_q == S_DONE);
  assign o_lsu_misalign = misalign_q;
  assign o_lsu_stall    = ((state_q == S_IDLE) && i_lsu_req) ||
                          (state_q == S_REQ) || (state_q == S_WAIT);
`ifdef RISCV_LSU_TIMEOUT_EN
  assign o_lsu_fault    = fault_q;
`else
  assign o_lsu_fault    = 1'b0;
`endif

endmodule
